// File: rtl/pipelined_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctrl_pkg : opcodes, ALU codes, mux encodings and the stage bundle    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package ctrl_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  // All-zero value of this bundle is the pipeline bubble.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       jalr;
    logic       alu_src;
    logic       alu_src_a;
    logic [3:0] alu_control;
    logic [2:0] funct3;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pipelined_ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ctrl_decode : combinational RV32I main + ALU decode for Decode stage |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int EXT_OPS = 1
) (
  input  logic [6:0] opD,
  input  logic [2:0] funct3D,
  input  logic       funct7b5D,
  output ctrl_t      ctrlD,
  output logic [2:0] ImmSrcD,
  output logic       IllegalD
);

  ctrl_t      w_main;
  logic [1:0] w_alu_op;
  logic [2:0] w_imm;
  logic       w_op_illegal;
  logic       w_fn_illegal;
  logic [3:0] w_alu;
  logic       w_ext;

  assign w_ext = (EXT_OPS != 0);

  always_comb begin
    w_main       = '0;
    w_alu_op     = 2'b00;
    w_imm        = IMM_I;
    w_op_illegal = 1'b0;
    case (opD)
      OP_LOAD: begin
        w_main.reg_write  = 1'b1;
        w_main.alu_src    = 1'b1;
        w_main.result_src = RES_MEM;
        w_op_illegal      = (funct3D != 3'b010);
      end
      OP_STORE: begin
        w_main.mem_write = 1'b1;
        w_main.alu_src   = 1'b1;
        w_imm            = IMM_S;
        w_op_illegal     = (funct3D != 3'b010);
      end
      OP_R: begin
        w_main.reg_write = 1'b1;
        w_alu_op         = 2'b10;
      end
      OP_I: begin
        w_main.reg_write = 1'b1;
        w_main.alu_src   = 1'b1;
        w_alu_op         = 2'b10;
      end
      OP_BR: begin
        w_main.branch = 1'b1;
        w_alu_op      = 2'b01;
        w_imm         = IMM_B;
        w_op_illegal  = (funct3D[2:1] == 2'b01);
      end
      OP_JAL: begin
        w_main.jump       = 1'b1;
        w_main.reg_write  = 1'b1;
        w_main.result_src = RES_PC4;
        w_imm             = IMM_J;
      end
      OP_JALR: begin
        w_main.jump       = 1'b1;
        w_main.jalr       = 1'b1;
        w_main.reg_write  = 1'b1;
        w_main.alu_src    = 1'b1;
        w_main.result_src = RES_PC4;
        w_op_illegal      = !w_ext || (funct3D != 3'b000);
      end
      OP_LUI: begin
        w_main.reg_write  = 1'b1;
        w_main.result_src = RES_IMM;
        w_imm             = IMM_U;
        w_op_illegal      = !w_ext;
      end
      OP_AUIPC: begin
        w_main.reg_write = 1'b1;
        w_main.alu_src_a = 1'b1;
        w_main.alu_src   = 1'b1;
        w_imm            = IMM_U;
        w_op_illegal     = !w_ext;
      end
      default: w_op_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_alu        = ALU_ADD;
    w_fn_illegal = 1'b0;
    case (w_alu_op)
      2'b01: w_alu = ALU_SUB;
      2'b10: begin
        case (funct3D)
          // Only the register form subtracts; addi ignores instr[30].
          3'b000: w_alu = ((opD == OP_R) && funct7b5D) ? ALU_SUB : ALU_ADD;
          3'b001: begin w_alu = ALU_SLL;  w_fn_illegal = !w_ext; end
          3'b010: w_alu = ALU_SLT;
          3'b011: begin w_alu = ALU_SLTU; w_fn_illegal = !w_ext; end
          3'b100: begin w_alu = ALU_XOR;  w_fn_illegal = !w_ext; end
          3'b101: begin
            w_alu        = funct7b5D ? ALU_SRA : ALU_SRL;
            w_fn_illegal = !w_ext;
          end
          3'b110: w_alu = ALU_OR;
          default: w_alu = ALU_AND;
        endcase
      end
      default: w_alu = ALU_ADD;
    endcase
  end

  assign IllegalD = w_op_illegal | w_fn_illegal;
  assign ImmSrcD  = IllegalD ? IMM_I : w_imm;

  // An illegal instruction enters the pipe as a bubble that still carries funct3.
  always_comb begin
    ctrlD             = w_main;
    ctrlD.alu_control = w_alu;
    if (IllegalD) ctrlD = '0;
    ctrlD.funct3 = funct3D;
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipelined_ctrl : ID/EX, EX/MEM, MEM/WB control regs + branch resolve |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
module pipelined_ctrl
  import ctrl_pkg::*;
#(
  parameter  int EXT_OPS = 1,
  localparam int ACW     = (EXT_OPS != 0) ? 4 : 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [6:0]     opD,
  input  logic [2:0]     funct3D,
  input  logic           funct7b5D,
  input  logic           FlushE,
  input  logic           StallE,
  input  logic           ZeroE,
  input  logic           LtE,
  input  logic           LtuE,
  output logic [2:0]     ImmSrcD,
  output logic           IllegalD,
  output logic [ACW-1:0] ALUControlE,
  output logic           ALUSrcE,
  output logic           ALUSrcAE,
  output logic           JalrE,
  output logic           PCSrcE,
  output logic           MemWriteM,
  output logic           RegWriteW,
  output logic [1:0]     ResultSrcW,
  output logic           RegWriteM,
  output logic [1:0]     ResultSrcM,
  output logic           ResultSrcE0
);

  ctrl_t      w_ctrl_d;
  ctrl_t      r_e;
  logic       r_m_reg_write;
  logic       r_m_mem_write;
  logic [1:0] r_m_result_src;
  logic       r_w_reg_write;
  logic [1:0] r_w_result_src;
  logic       w_taken;

  ctrl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
    .opD       (opD),
    .funct3D   (funct3D),
    .funct7b5D (funct7b5D),
    .ctrlD     (w_ctrl_d),
    .ImmSrcD   (ImmSrcD),
    .IllegalD  (IllegalD)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_e <= '0;
    else if (FlushE)  r_e <= '0;
    else if (!StallE) r_e <= w_ctrl_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_reg_write  <= 1'b0;
      r_m_mem_write  <= 1'b0;
      r_m_result_src <= RES_ALU;
      r_w_reg_write  <= 1'b0;
      r_w_result_src <= RES_ALU;
    end else begin
      r_m_reg_write  <= r_e.reg_write;
      r_m_mem_write  <= r_e.mem_write;
      r_m_result_src <= r_e.result_src;
      r_w_reg_write  <= r_m_reg_write;
      r_w_result_src <= r_m_result_src;
    end
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_e.funct3)
      3'b000:  w_taken = ZeroE;
      3'b001:  w_taken = !ZeroE;
      3'b100:  w_taken = LtE;
      3'b101:  w_taken = !LtE;
      3'b110:  w_taken = LtuE;
      3'b111:  w_taken = !LtuE;
      default: w_taken = 1'b0;
    endcase
  end

  // Redirect is resolved in the same cycle; the hazard unit owns the follow-up flush.
  assign PCSrcE      = r_e.jump | (r_e.branch & w_taken);
  assign ALUControlE = r_e.alu_control[ACW-1:0];
  assign ALUSrcE     = r_e.alu_src;
  assign ALUSrcAE    = r_e.alu_src_a;
  assign JalrE       = r_e.jalr;
  assign ResultSrcE0 = r_e.result_src[0];
  assign MemWriteM   = r_m_mem_write;
  assign RegWriteM   = r_m_reg_write;
  assign ResultSrcM  = r_m_result_src;
  assign RegWriteW   = r_w_reg_write;
  assign ResultSrcW  = r_w_result_src;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipelined_ctrl : both EXT_OPS variants against a mnemonic model   |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_pipelined_ctrl;

  typedef enum int {
    M_BAD, M_LW, M_SW, M_BR, M_JAL, M_JALR, M_LUI, M_AUIPC,
    M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT, M_SLL, M_SRL, M_SRA, M_SLTU
  } mnem_e;

  typedef struct packed {
    logic       regw;
    logic [1:0] rsrc;
    logic       memw;
    logic       jump;
    logic       branch;
    logic       jalr;
    logic       alusrc;
    logic       alusrca;
    logic [3:0] alu;
    logic [2:0] f3;
  } stage_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opD;
  logic [2:0] funct3D;
  logic       funct7b5D, FlushE, StallE, ZeroE, LtE, LtuE;

  logic [2:0] d1_imm, d0_imm;
  logic       d1_ill, d0_ill;
  logic [3:0] d1_alu;
  logic [2:0] d0_alu;
  logic       d1_asrc, d0_asrc, d1_asrca, d0_asrca, d1_jalr, d0_jalr;
  logic       d1_pcsrc, d0_pcsrc, d1_memwM, d0_memwM, d1_regwW, d0_regwW;
  logic [1:0] d1_rsrcW, d0_rsrcW, d1_rsrcM, d0_rsrcM;
  logic       d1_regwM, d0_regwM, d1_rse0, d0_rse0;

  int checks = 0;
  int failures = 0;

  stage_t e_q [2];
  stage_t m_q [2];
  stage_t w_q [2];

  logic [6:0] ops [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};

  always #5 clk = ~clk;

  pipelined_ctrl #(.EXT_OPS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
    .FlushE(FlushE), .StallE(StallE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(d1_imm), .IllegalD(d1_ill), .ALUControlE(d1_alu), .ALUSrcE(d1_asrc),
    .ALUSrcAE(d1_asrca), .JalrE(d1_jalr), .PCSrcE(d1_pcsrc), .MemWriteM(d1_memwM),
    .RegWriteW(d1_regwW), .ResultSrcW(d1_rsrcW), .RegWriteM(d1_regwM),
    .ResultSrcM(d1_rsrcM), .ResultSrcE0(d1_rse0)
  );

  pipelined_ctrl #(.EXT_OPS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
    .FlushE(FlushE), .StallE(StallE), .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .ImmSrcD(d0_imm), .IllegalD(d0_ill), .ALUControlE(d0_alu), .ALUSrcE(d0_asrc),
    .ALUSrcAE(d0_asrca), .JalrE(d0_jalr), .PCSrcE(d0_pcsrc), .MemWriteM(d0_memwM),
    .RegWriteW(d0_regwW), .ResultSrcW(d0_rsrcW), .RegWriteM(d0_regwM),
    .ResultSrcM(d0_rsrcM), .ResultSrcE0(d0_rse0)
  );

  function automatic mnem_e classify(input bit ext, input logic [6:0] op,
                                     input logic [2:0] f3, input logic f7);
    mnem_e m = M_BAD;
    case (op)
      7'b0000011: if (f3 == 3'b010) m = M_LW;
      7'b0100011: if (f3 == 3'b010) m = M_SW;
      7'b0110011, 7'b0010011: begin
        case (f3)
          3'd0: m = (op == 7'b0110011 && f7) ? M_SUB : M_ADD;
          3'd1: if (ext) m = M_SLL;
          3'd2: m = M_SLT;
          3'd3: if (ext) m = M_SLTU;
          3'd4: if (ext) m = M_XOR;
          3'd5: if (ext) m = f7 ? M_SRA : M_SRL;
          3'd6: m = M_OR;
          default: m = M_AND;
        endcase
      end
      7'b1100011: if (f3 != 3'd2 && f3 != 3'd3) m = M_BR;
      7'b1101111: m = M_JAL;
      7'b1100111: if (ext && f3 == 3'd0) m = M_JALR;
      7'b0110111: if (ext) m = M_LUI;
      7'b0010111: if (ext) m = M_AUIPC;
      default: m = M_BAD;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] alu_code(input mnem_e m);
    case (m)
      M_SUB, M_BR: return 4'd1;
      M_AND:  return 4'd2;
      M_OR:   return 4'd3;
      M_XOR:  return 4'd4;
      M_SLT:  return 4'd5;
      M_SLL:  return 4'd6;
      M_SRL:  return 4'd7;
      M_SRA:  return 4'd8;
      M_SLTU: return 4'd9;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input mnem_e m);
    case (m)
      M_SW: return 3'd1;
      M_BR: return 3'd2;
      M_JAL: return 3'd3;
      M_LUI, M_AUIPC: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic stage_t expect_ctrl(input bit ext, input logic [6:0] op,
                                         input logic [2:0] f3, input logic f7);
    stage_t s = '0;
    mnem_e m = classify(ext, op, f3, f7);
    s.f3 = f3;
    case (m)
      M_LW:    begin s.regw = 1; s.alusrc = 1; s.rsrc = 2'd1; end
      M_SW:    begin s.memw = 1; s.alusrc = 1; end
      M_BR:    begin s.branch = 1; s.alu = alu_code(m); end
      M_JAL:   begin s.jump = 1; s.regw = 1; s.rsrc = 2'd2; end
      M_JALR:  begin s.jump = 1; s.jalr = 1; s.regw = 1; s.alusrc = 1; s.rsrc = 2'd2; end
      M_LUI:   begin s.regw = 1; s.rsrc = 2'd3; end
      M_AUIPC: begin s.regw = 1; s.alusrca = 1; s.alusrc = 1; end
      M_ADD, M_SUB, M_AND, M_OR, M_XOR, M_SLT, M_SLL, M_SRL, M_SRA, M_SLTU: begin
        s.regw   = 1;
        s.alusrc = (op == 7'b0010011);
        s.alu    = alu_code(m);
      end
      default: ;
    endcase
    return s;
  endfunction

  function automatic logic pcsrc_of(input stage_t e, input logic z, input logic lt, input logic ltu);
    if (e.jump) return 1'b1;
    if (!e.branch) return 1'b0;
    case (e.f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int x = 0; x < 2; x++) begin
      e_q[x] = '0; m_q[x] = '0; w_q[x] = '0;
    end
  endtask

  task automatic check_all();
    chk("d1_immD",  32'(d1_imm),  32'(imm_of(classify(1, opD, funct3D, funct7b5D))));
    chk("d0_immD",  32'(d0_imm),  32'(imm_of(classify(0, opD, funct3D, funct7b5D))));
    chk("d1_illD",  32'(d1_ill),  32'(classify(1, opD, funct3D, funct7b5D) == M_BAD));
    chk("d0_illD",  32'(d0_ill),  32'(classify(0, opD, funct3D, funct7b5D) == M_BAD));
    chk("d1_aluE",  32'(d1_alu),  32'(e_q[1].alu));
    chk("d0_aluE",  32'(d0_alu),  32'(e_q[0].alu));
    chk("d1_asrcE", 32'(d1_asrc), 32'(e_q[1].alusrc));
    chk("d0_asrcE", 32'(d0_asrc), 32'(e_q[0].alusrc));
    chk("d1_asrcaE",32'(d1_asrca),32'(e_q[1].alusrca));
    chk("d0_asrcaE",32'(d0_asrca),32'(e_q[0].alusrca));
    chk("d1_jalrE", 32'(d1_jalr), 32'(e_q[1].jalr));
    chk("d0_jalrE", 32'(d0_jalr), 32'(e_q[0].jalr));
    chk("d1_rse0",  32'(d1_rse0), 32'(e_q[1].rsrc[0]));
    chk("d0_rse0",  32'(d0_rse0), 32'(e_q[0].rsrc[0]));
    chk("d1_pcsrc", 32'(d1_pcsrc), 32'(pcsrc_of(e_q[1], ZeroE, LtE, LtuE)));
    chk("d0_pcsrc", 32'(d0_pcsrc), 32'(pcsrc_of(e_q[0], ZeroE, LtE, LtuE)));
    chk("d1_memwM", 32'(d1_memwM), 32'(m_q[1].memw));
    chk("d0_memwM", 32'(d0_memwM), 32'(m_q[0].memw));
    chk("d1_regwM", 32'(d1_regwM), 32'(m_q[1].regw));
    chk("d0_regwM", 32'(d0_regwM), 32'(m_q[0].regw));
    chk("d1_rsrcM", 32'(d1_rsrcM), 32'(m_q[1].rsrc));
    chk("d0_rsrcM", 32'(d0_rsrcM), 32'(m_q[0].rsrc));
    chk("d1_regwW", 32'(d1_regwW), 32'(w_q[1].regw));
    chk("d0_regwW", 32'(d0_regwW), 32'(w_q[0].regw));
    chk("d1_rsrcW", 32'(d1_rsrcW), 32'(w_q[1].rsrc));
    chk("d0_rsrcW", 32'(d0_rsrcW), 32'(w_q[0].rsrc));
  endtask

  // Drive one cycle of inputs, compare, then advance the model across the clock edge.
  task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic fl, input logic st,
                     input logic z, input logic lt, input logic ltu);
    opD = op; funct3D = f3; funct7b5D = f7; FlushE = fl; StallE = st;
    ZeroE = z; LtE = lt; LtuE = ltu;
    #1;
    check_all();
    @(posedge clk);
    for (int x = 0; x < 2; x++) begin
      if (!rst_n) begin
        e_q[x] = '0; m_q[x] = '0; w_q[x] = '0;
      end else begin
        w_q[x] = m_q[x];
        m_q[x] = e_q[x];
        if (fl) e_q[x] = '0;
        else if (!st) e_q[x] = expect_ctrl(x[0], op, f3, f7);
      end
    end
    #1;
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    rst_n = 1'b0;
    opD = '0; funct3D = '0; funct7b5D = 0; FlushE = 0; StallE = 0;
    ZeroE = 0; LtE = 0; LtuE = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwW", 32'(d1_regwW), 0);
    chk("rst_memwM", 32'(d1_memwM), 0);
    chk("rst_pcsrc", 32'(d1_pcsrc), 0);
    chk("rst_aluE",  32'(d1_alu), 0);
    check_all();
    rst_n = 1'b1;

    // sw: store strobe only after the second edge
    cyc(7'b0100011, 3'b010, 0, 0, 0, 0, 0, 0);
    chk("sw_memwM_e1", 32'(d1_memwM), 0);
    cyc(7'b0000000, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("sw_memwM_e2", 32'(d1_memwM), 1);

    // lw: write-back after the third edge
    cyc(7'b0000011, 3'b010, 0, 0, 0, 0, 0, 0);
    cyc(7'b0000000, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("lw_regwW_e2", 32'(d1_regwW), 0);
    cyc(7'b0000000, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("lw_regwW_e3", 32'(d1_regwW), 1);
    chk("lw_rsrcW_e3", 32'(d1_rsrcW), 1);

    // bge taken / not taken, then reserved branch funct3
    cyc(7'b1100011, 3'b101, 0, 0, 0, 0, 0, 0);
    LtE = 0; #1;
    chk("bge_taken", 32'(d1_pcsrc), 1);
    LtE = 1; #1;
    chk("bge_nt", 32'(d1_pcsrc), 0);
    cyc(7'b1100011, 3'b010, 0, 0, 0, 1, 1, 1);
    chk("br010_ill", 32'(d1_ill), 1);
    ZeroE = 0; LtE = 0; LtuE = 0; #1;
    chk("br010_pcsrc", 32'(d1_pcsrc), 0);

    // flush beats stall; stall holds E
    cyc(7'b0110011, 3'b000, 1, 0, 0, 0, 0, 0);
    chk("sub_aluE", 32'(d1_alu), 1);
    cyc(7'b0110011, 3'b000, 1, 1, 1, 0, 0, 0);
    chk("flush_aluE", 32'(d1_alu), 0);
    cyc(7'b0110011, 3'b000, 1, 0, 0, 0, 0, 0);
    cyc(7'b0110011, 3'b111, 0, 0, 1, 0, 0, 0);
    chk("stall1_aluE", 32'(d1_alu), 1);
    cyc(7'b0110011, 3'b111, 0, 0, 1, 0, 0, 0);
    chk("stall2_aluE", 32'(d1_alu), 1);

    // extended ops vs base
    cyc(7'b0110011, 3'b101, 1, 0, 0, 0, 0, 0);
    chk("sra_aluE", 32'(d1_alu), 8);
    cyc(7'b0110111, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("lui_immD", 32'(d1_imm), 4);
    chk("lui_ill_base", 32'(d0_ill), 1);
    cyc(7'b0000000, 3'b000, 0, 0, 0, 0, 0, 0);
    cyc(7'b0000000, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("lui_rsrcW", 32'(d1_rsrcW), 3);
    chk("lui_regwW_base", 32'(d0_regwW), 0);

    // async reset with work in flight
    cyc(7'b0000011, 3'b010, 0, 0, 0, 0, 0, 0);
    cyc(7'b0100011, 3'b010, 0, 0, 0, 0, 0, 0);
    cyc(7'b1101111, 3'b000, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_pcsrc", 32'(d1_pcsrc), 1);
    chk("pre_rst_memwM", 32'(d1_memwM), 1);
    chk("pre_rst_regwW", 32'(d1_regwW), 1);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("async_rst_pcsrc", 32'(d1_pcsrc), 0);
    chk("async_rst_memwM", 32'(d1_memwM), 0);
    chk("async_rst_regwW", 32'(d1_regwW), 0);
    cyc(7'b0000011, 3'b010, 0, 0, 1, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      int idx;
      idx = $urandom_range(0, 9);
      op  = (idx == 9) ? 7'($urandom) : ops[idx];
      f3  = 3'($urandom_range(0, 7));
      if ((idx <= 1) && ($urandom_range(0, 1) == 0)) f3 = 3'b010;
      if (i == 250) begin
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all();
      end
      cyc(op, f3, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
